// File: rtl/transceiver_pkg.sv
// Shared line-level definitions for the serial transmitter and receiver/decoder pair.
// Frame on the wire: start(0), 8 data bits LSB-first, odd parity, stop(1).
package transceiver_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } tx_state_e;

   localparam int FRAME_DATA_BITS = 8;
   localparam int FRAME_BITS      = 11;

   localparam logic IDLE_LEVEL  = 1'b1;
   localparam logic START_LEVEL = 1'b0;
   localparam logic STOP_LEVEL  = 1'b1;

   // Parity bit sits above the data so a right shift walks it onto bit 0 after the data.
   typedef struct packed {
      logic                       parity;
      logic [FRAME_DATA_BITS-1:0] data;
   } enc_word_t;

   function automatic logic odd_parity(input logic [FRAME_DATA_BITS-1:0] d);
      return ~^d;
   endfunction

endpackage

// File: rtl/transmitter_encoder.sv
// Combinational byte encoder: appends the odd-parity bit to the data byte.
// Mirror of the decoder on the receive side.
module encoder
   import transceiver_pkg::*;
(
   input  logic [FRAME_DATA_BITS-1:0] data_i,
   output enc_word_t                  word_o
);

   always_comb begin
      word_o.data   = data_i;
      word_o.parity = odd_parity(data_i);
   end

endmodule

// File: rtl/transmitter.sv
// Serial frame transmitter with valid/ready byte input.
// Outputs are registered from next-state values so they change exactly on the clock edge.
module transmitter
   import transceiver_pkg::*;
#(
   parameter int CLKS_PER_BIT = 1
) (
   input  logic                       clk,
   input  logic                       arst,
   input  logic [FRAME_DATA_BITS-1:0] in_byte,
   input  logic                       in_valid,
   output logic                       in_ready,
   output logic                       out,
   output logic                       busy,
   output logic                       done
);

   localparam int            CW       = $clog2(CLKS_PER_BIT) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

   tx_state_e     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [8:0]    shreg_q, shreg_d;
   logic          out_q, out_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          in_ready_q, in_ready_d;

   enc_word_t     enc_word;
   logic          accept;
   logic          bit_last;
   logic          stop_last_d;

   encoder u_encoder (
      .data_i (in_byte),
      .word_o (enc_word)
   );

   assign accept   = in_valid & in_ready_q;
   assign bit_last = (cnt_q == CNT_LAST);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shreg_d = shreg_q;

      if (state_q != ST_IDLE) begin
         cnt_d = bit_last ? '0 : cnt_q + 1'b1;
      end

      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = ST_START;
               cnt_d   = '0;
               shreg_d = enc_word;
            end
         end
         ST_START: begin
            if (bit_last) begin
               state_d = ST_DATA;
               idx_d   = '0;
            end
         end
         ST_DATA: begin
            if (bit_last) begin
               shreg_d = {1'b0, shreg_q[8:1]};
               idx_d   = idx_q + 3'd1;
               if (idx_q == 3'd7) state_d = ST_PARITY;
            end
         end
         ST_PARITY: begin
            if (bit_last) state_d = ST_STOP;
         end
         ST_STOP: begin
            // Accept on the final stop clk chains straight into the next start bit.
            if (bit_last) begin
               if (accept) begin
                  state_d = ST_START;
                  shreg_d = enc_word;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      unique case (state_d)
         ST_START:            out_d = START_LEVEL;
         ST_DATA, ST_PARITY:  out_d = shreg_d[0];
         ST_STOP:             out_d = STOP_LEVEL;
         default:             out_d = IDLE_LEVEL;
      endcase

      stop_last_d = (state_d == ST_STOP) && (cnt_d == CNT_LAST);
      done_d      = stop_last_d;
      in_ready_d  = (state_d == ST_IDLE) || stop_last_d;
      busy_d      = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         shreg_q    <= '0;
         out_q      <= IDLE_LEVEL;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         in_ready_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         shreg_q    <= shreg_d;
         out_q      <= out_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         in_ready_q <= in_ready_d;
      end
   end

   assign out      = out_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign in_ready = in_ready_q;

endmodule
